// File: rtl/serial_alu24_if.sv
// serial_alu24_if: start/busy/done handshake and operand/result bus for serial_alu24.
interface serial_alu24_if #(parameter int WIDTH = 24);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       alu_op;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry_out;
  logic             overflow;
  modport master (output start, a, b, alu_op, input busy, done, result, zero, carry_out, overflow);
  modport slave  (input start, a, b, alu_op, output busy, done, result, zero, carry_out, overflow);
endinterface

// File: rtl/serial_alu24.sv
// serial_alu24: bit-serial 24-bit ALU, one bit per clock LSB first, start/busy/done handshake.
// Define SERIAL_ALU_FLAGS_EN to enable zero/carry_out/overflow; otherwise they are tied to 0.
module serial_alu24 #(parameter int WIDTH = 24) (
  input  logic          clk,
  input  logic          reset,
  serial_alu24_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [2:0] OP_AND = 3'b000, OP_OR = 3'b001, OP_ADD = 3'b010,
                         OP_SLT = 3'b011, OP_XOR = 3'b101, OP_SUB = 3'b110;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_acc, r_result;
  logic [2:0]       r_op;
  logic [CW-1:0]    r_cnt;
  logic             r_c;
  logic             w_last, w_inv, w_bb, w_sum, w_cn, w_bit, w_ovf;
  logic [WIDTH-1:0] w_acc, w_res;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (bus.start ? RUN : IDLE) :
             (r_state == RUN)  ? (w_last ? DONE : RUN) : IDLE;
  end
  // SUB and SLT add the inverted B with an initial carry of 1
  assign w_last = r_cnt == CW'(WIDTH - 1);
  assign w_inv  = (r_op == OP_SUB) || (r_op == OP_SLT);
  assign w_bb   = r_b[0] ^ w_inv;
  assign w_sum  = r_a[0] ^ w_bb ^ r_c;
  assign w_cn   = (r_a[0] & w_bb) | (r_a[0] & r_c) | (w_bb & r_c);
  assign w_ovf  = r_c ^ w_cn;
  assign w_bit  = (r_op == OP_AND) ? (r_a[0] & r_b[0]) :
                  (r_op == OP_OR)  ? (r_a[0] | r_b[0]) :
                  (r_op == OP_XOR) ? (r_a[0] ^ r_b[0]) :
                  (r_op == OP_ADD || r_op == OP_SUB) ? w_sum : 1'b0;
  assign w_acc  = {w_bit, r_acc[WIDTH-1:1]};
  assign w_res  = (r_op == OP_SLT) ? {{(WIDTH-1){1'b0}}, w_sum ^ w_ovf} : w_acc;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_op     <= '0;
      r_cnt    <= '0;
      r_c      <= 1'b0;
    end else if (r_state == IDLE && bus.start) begin
      r_a   <= bus.a;
      r_b   <= bus.b;
      r_op  <= bus.alu_op;
      r_cnt <= '0;
      r_acc <= '0;
      r_c   <= (bus.alu_op == OP_SUB) || (bus.alu_op == OP_SLT);
    end else if (r_state == RUN) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_c   <= w_cn;
      r_acc <= w_acc;
      r_cnt <= w_last ? r_cnt : r_cnt + CW'(1);
      if (w_last) r_result <= w_res;
    end
`ifdef SERIAL_ALU_FLAGS_EN
  logic w_arith, r_zero, r_cout, r_ovf;
  assign w_arith = (r_op == OP_ADD) || (r_op == OP_SUB);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_zero <= 1'b0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (r_state == RUN && w_last) begin
      r_zero <= w_res == '0;
      r_cout <= w_arith & w_cn;
      r_ovf  <= w_arith & w_ovf;
    end
  assign bus.zero      = r_zero;
  assign bus.carry_out = r_cout;
  assign bus.overflow  = r_ovf;
`else
  assign bus.zero      = 1'b0;
  assign bus.carry_out = 1'b0;
  assign bus.overflow  = 1'b0;
`endif
  assign bus.busy   = r_state != IDLE;
  assign bus.done   = r_state == DONE;
  assign bus.result = r_result;
endmodule
